ps2_move_decoder: RTL and testbench

Receives raw PS/2 keyboard traffic on PS2_CLK/PS2_DAT, recovers 11-bit frames, validates them, and turns scan-code sequences into one-cycle Tetris move strobes for the game-control FSM. Sits between the board's PS/2 pins and the game logic inside `tetris`, in the input-conditioning path next to the KEY debouncers. Host-to-device transmission is not supported; the block only listens.

---
 rtl/tetris_input_pkg.sv | 32 +++
 rtl/ps2_frame_rx.sv | 158 +++++++++++++++
 rtl/ps2_move_decoder.sv | 96 +++++++++
 tb/tb_ps2_move_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tetris_input_pkg.sv
// Shared definitions for the PS/2 keyboard input path: scan codes, the
// frame-receiver state encoding and the frame parity check.
package tetris_input_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_SPACE = 8'h29;

    // Move vector bit positions: {left, right, rotate, soft_drop, hard_drop}
    localparam logic [4:0] MV_NONE  = 5'b00000;
    localparam logic [4:0] MV_LEFT  = 5'b10000;
    localparam logic [4:0] MV_RIGHT = 5'b01000;
    localparam logic [4:0] MV_ROT   = 5'b00100;
    localparam logic [4:0] MV_SOFT  = 5'b00010;
    localparam logic [4:0] MV_HARD  = 5'b00001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, clock glitch filter,
// 11-bit frame FSM with parity/stop validation and a mid-frame timeout.
module ps2_frame_rx
    import tetris_input_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned     TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_ZERO = TMO_W'(0);

    logic             clk_meta_r, clk_sync_r, dat_meta_r, dat_sync_r;
    logic             filt_clk_r, fall_r;
    logic [7:0]       filt_cnt_r;
    frame_state_e     state_r, state_next_s;
    logic [7:0]       shift_r, byte_data_r;
    logic [2:0]       bit_cnt_r;
    logic             par_r, byte_valid_r, frame_err_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             timeout_s, good_s, bad_s;

    // Two-flop synchronizers, idle-high like the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clk;
            clk_sync_r <= clk_meta_r;
            dat_meta_r <= ps2_dat;
            dat_sync_r <= dat_meta_r;
        end
    end

    // Glitch filter: follow the bus clock only after FILTER_LEN differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_clk_r <= 1'b1;
            filt_cnt_r <= 8'd0;
            fall_r     <= 1'b0;
        end else if (clk_sync_r != filt_clk_r) begin
            if (filt_cnt_r == FILT_LAST) begin
                filt_clk_r <= clk_sync_r;
                filt_cnt_r <= 8'd0;
                fall_r     <= ~clk_sync_r;
            end else begin
                filt_cnt_r <= filt_cnt_r + 8'd1;
                fall_r     <= 1'b0;
            end
        end else begin
            filt_cnt_r <= 8'd0;
            fall_r     <= 1'b0;
        end
    end

    assign timeout_s = (state_r != ST_IDLE) && !fall_r && (tmo_cnt_r == TMO_LAST);

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame next-state logic; a bad start bit simply leaves the FSM idle
    always_comb begin
        state_next_s = state_r;
        if (timeout_s) begin
            state_next_s = ST_IDLE;
        end else if (fall_r) begin
            case (state_r)
                ST_IDLE:   state_next_s = dat_sync_r ? ST_IDLE : ST_DATA;
                ST_DATA:   state_next_s = (bit_cnt_r == 3'd7) ? ST_PARITY : ST_DATA;
                ST_PARITY: state_next_s = ST_STOP;
                ST_STOP:   state_next_s = ST_IDLE;
                default:   state_next_s = ST_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Frame verdict on the stop-bit edge or on timeout
    always_comb begin
        good_s = 1'b0;
        bad_s  = 1'b0;
        if (timeout_s) begin
            bad_s = 1'b1;
        end else if (fall_r && (state_r == ST_STOP)) begin
            good_s = dat_sync_r && odd_parity_ok(shift_r, par_r);
            bad_s  = !(dat_sync_r && odd_parity_ok(shift_r, par_r));
        end else begin
            good_s = 1'b0;
            bad_s  = 1'b0;
        end
    end

    // Bit capture and registered frame results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r      <= 8'd0;
            bit_cnt_r    <= 3'd0;
            par_r        <= 1'b0;
            byte_data_r  <= 8'd0;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            byte_valid_r <= good_s;
            frame_err_r  <= bad_s;
            if (good_s) begin
                byte_data_r <= shift_r;
            end
            if (fall_r) begin
                case (state_r)
                    ST_IDLE:   bit_cnt_r <= 3'd0;
                    ST_DATA: begin
                        shift_r   <= {dat_sync_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                    end
                    ST_PARITY: par_r <= dat_sync_r;
                    default:   bit_cnt_r <= bit_cnt_r;
                endcase
            end
        end
    end

    // Mid-frame inactivity counter, restarted by every consumed clock fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= TMO_ZERO;
        end else if (fall_r || timeout_s || (state_r == ST_IDLE)) begin
            tmo_cnt_r <= TMO_ZERO;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end
    end

    assign byte_valid = byte_valid_r;
    assign byte_data  = byte_data_r;
    assign frame_err  = frame_err_r;

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard to Tetris move strobes: frame receiver plus E0/F0 prefix
// decoder producing one-cycle move pulses.
module ps2_move_decoder
    import tetris_input_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       move_left,
    output logic       move_right,
    output logic       rotate,
    output logic       soft_drop,
    output logic       hard_drop
);

    logic       rx_valid_s, rx_err_s;
    logic [7:0] rx_byte_s;
    logic       ext_r, brk_r;
    logic [4:0] move_s, move_r;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (CLOCK_50),
        .rst        (reset),
        .ps2_clk    (PS2_CLK),
        .ps2_dat    (PS2_DAT),
        .byte_valid (rx_valid_s),
        .byte_data  (rx_byte_s),
        .frame_err  (rx_err_s)
    );

    // Prefix flags: any final byte or a bad frame ends the current sequence
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            ext_r <= 1'b0;
            brk_r <= 1'b0;
        end else if (rx_err_s) begin
            ext_r <= 1'b0;
            brk_r <= 1'b0;
        end else if (rx_valid_s) begin
            case (rx_byte_s)
                SC_EXT: ext_r <= 1'b1;
                SC_BRK: brk_r <= 1'b1;
                default: begin
                    ext_r <= 1'b0;
                    brk_r <= 1'b0;
                end
            endcase
        end
    end

    // Make-code lookup; the extended flag must match for a code to count
    always_comb begin
        move_s = MV_NONE;
        if (rx_valid_s && !brk_r) begin
            case ({ext_r, rx_byte_s})
                {1'b1, SC_LEFT}:  move_s = MV_LEFT;
                {1'b1, SC_RIGHT}: move_s = MV_RIGHT;
                {1'b1, SC_UP}:    move_s = MV_ROT;
                {1'b1, SC_DOWN}:  move_s = MV_SOFT;
                {1'b0, SC_SPACE}: move_s = MV_HARD;
                default:          move_s = MV_NONE;
            endcase
        end else begin
            move_s = MV_NONE;
        end
    end

    // Registered move strobes
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            move_r <= MV_NONE;
        end else begin
            move_r <= move_s;
        end
    end

    assign byte_valid = rx_valid_s;
    assign byte_data  = rx_byte_s;
    assign frame_err  = rx_err_s;
    assign move_left  = move_r[4];
    assign move_right = move_r[3];
    assign rotate     = move_r[2];
    assign soft_drop  = move_r[1];
    assign hard_drop  = move_r[0];

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench for ps2_move_decoder: a scheduled expected-output model
// checked every cycle, plus literal pulse-count and byte checks.
module tb_ps2_move_decoder;

    localparam int F = 4;
    localparam int T = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       byte_valid, frame_err, move_left, move_right, rotate, soft_drop, hard_drop;
    logic [7:0] byte_data;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int cnt_bv = 0, cnt_fe = 0, cnt_l = 0, cnt_r = 0, cnt_rot = 0, cnt_soft = 0, cnt_hard = 0;

    // Expected {byte_valid, frame_err, left, right, rotate, soft, hard} by cycle
    logic [6:0] sched [int];
    logic [7:0] sched_byte [int];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [6:0] exp_v;
    logic [7:0] exp_byte = 8'h00;
    logic [6:0] act_v;

    ps2_move_decoder #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .PS2_CLK    (ps2_clk),
        .PS2_DAT    (ps2_dat),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err),
        .move_left  (move_left),
        .move_right (move_right),
        .rotate     (rotate),
        .soft_drop  (soft_drop),
        .hard_drop  (hard_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    task automatic add_exp(input int c, input logic [6:0] m);
        if (!sched.exists(c)) sched[c] = 7'd0;
        sched[c] = sched[c] | m;
    endtask

    // Good byte seen by the keyboard protocol model at output cycle c
    task automatic model_byte(input logic [7:0] b, input int c);
        logic [6:0] m;
        add_exp(c, 7'b1000000);
        sched_byte[c] = b;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            m = 7'd0;
            if (!m_brk) begin
                if (m_ext && b == 8'h6B)       m = 7'b0010000;
                else if (m_ext && b == 8'h74)  m = 7'b0001000;
                else if (m_ext && b == 8'h75)  m = 7'b0000100;
                else if (m_ext && b == 8'h72)  m = 7'b0000010;
                else if (!m_ext && b == 8'h29) m = 7'b0000001;
                else                           m = 7'd0;
            end
            if (m != 7'd0) add_exp(c + 1, m);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // Send the first nbits bits of a frame at 100 cycles/bit, scheduling outcomes
    task automatic send_frame(input logic [7:0] b, input logic flip, input int nbits, input logic exp_tmo);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            repeat (25) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                if (flip) begin
                    add_exp(cyc + F + 3, 7'b0100000);
                    m_ext = 1'b0;
                    m_brk = 1'b0;
                end else begin
                    model_byte(b, cyc + F + 3);
                end
            end else if (i == nbits - 1 && exp_tmo) begin
                add_exp(cyc + F + 3 + T, 7'b0100000);
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
            repeat (50) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (25) @(negedge clk);
        end
        repeat (30) @(negedge clk);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                #1;
                exp_v = sched.exists(cyc) ? sched[cyc] : 7'd0;
                if (sched_byte.exists(cyc)) exp_byte = sched_byte[cyc];
                if (rst) begin
                    exp_v    = 7'd0;
                    exp_byte = 8'h00;
                end
                act_v = {byte_valid, frame_err, move_left, move_right, rotate, soft_drop, hard_drop};
                chk("outputs", {17'd0, act_v, byte_data}, {17'd0, exp_v, exp_byte});
                cnt_bv   += int'(byte_valid);
                cnt_fe   += int'(frame_err);
                cnt_l    += int'(move_left);
                cnt_r    += int'(move_right);
                cnt_rot  += int'(rotate);
                cnt_soft += int'(soft_drop);
                cnt_hard += int'(hard_drop);
            end
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("reset_byte", {24'd0, byte_data}, 32'h00);

        // Space make
        send_frame(8'h29, 1'b0, 11, 1'b0);
        chk("t1_hard_cnt", cnt_hard, 32'd1);
        chk("t1_bv_cnt", cnt_bv, 32'd1);
        chk("t1_byte", {24'd0, byte_data}, 32'h29);

        // Left make, then Left break
        send_frame(8'hE0, 1'b0, 11, 1'b0);
        send_frame(8'h6B, 1'b0, 11, 1'b0);
        send_frame(8'hE0, 1'b0, 11, 1'b0);
        send_frame(8'hF0, 1'b0, 11, 1'b0);
        send_frame(8'h6B, 1'b0, 11, 1'b0);
        chk("t2_left_cnt", cnt_l, 32'd1);
        chk("t2_bv_cnt", cnt_bv, 32'd6);

        // Parity error keeps the old byte, then Up make
        send_frame(8'h1C, 1'b1, 11, 1'b0);
        chk("t3_fe_cnt", cnt_fe, 32'd1);
        chk("t3_bv_cnt", cnt_bv, 32'd6);
        chk("t3_byte_held", {24'd0, byte_data}, 32'h6B);
        send_frame(8'hE0, 1'b0, 11, 1'b0);
        send_frame(8'h75, 1'b0, 11, 1'b0);
        chk("t3_rot_cnt", cnt_rot, 32'd1);

        // Short clock glitches between prefix and code
        send_frame(8'hE0, 1'b0, 11, 1'b0);
        for (int g = 0; g < 3; g++) begin
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (30) @(negedge clk);
        end
        send_frame(8'h72, 1'b0, 11, 1'b0);
        chk("t4_soft_cnt", cnt_soft, 32'd1);
        chk("t4_bv_cnt", cnt_bv, 32'd10);

        // Truncated frame times out, then Right make
        send_frame(8'h74, 1'b0, 6, 1'b1);
        repeat (T + 50) @(negedge clk);
        chk("t5_fe_cnt", cnt_fe, 32'd2);
        send_frame(8'hE0, 1'b0, 11, 1'b0);
        send_frame(8'h74, 1'b0, 11, 1'b0);
        chk("t5_right_cnt", cnt_r, 32'd1);

        // Reset mid-frame after a prefix drops the prefix
        send_frame(8'hE0, 1'b0, 11, 1'b0);
        send_frame(8'h74, 1'b0, 4, 1'b0);
        rst = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
        #2;
        chk("t6_reset_outs",
            {23'd0, byte_valid, frame_err, move_left, move_right, rotate, soft_drop, hard_drop, byte_data},
            32'd0);
        @(negedge clk);
        rst = 1'b0;
        ps2_dat = 1'b1;
        repeat (50) @(negedge clk);
        send_frame(8'h74, 1'b0, 11, 1'b0);
        chk("t6_right_cnt", cnt_r, 32'd1);
        chk("t6_byte", {24'd0, byte_data}, 32'h74);
        chk("t6_bv_cnt", cnt_bv, 32'd14);
        chk("total_moves", cnt_l + cnt_r + cnt_rot + cnt_soft + cnt_hard, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
